// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with a valid/ready handshake and a one-entry
// skid buffer. It carries the decoded control word, both register-read
// operands, the sign-extended immediate and the Rs/Rt/Rd indices.
// Empty slots always hold an all-zero payload, so a bubble reads as zeros
// on every out_* field. A saturating counter records the cycles in which
// EX applies backpressure to a valid payload.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    // decode side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_rdata1,
    input  logic [DATA_W-1:0] in_rdata2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    // execute side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_rdata1,
    output logic [DATA_W-1:0] out_rdata2,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    // performance monitor
    output logic [CNT_W-1:0]  stall_cnt
);

    // One complete ID/EX payload, held as a single packed word.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } payload_t;

    // Occupancy encoded as {m_v, s_v}; 2'b01 (skid without main) never occurs.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    payload_t          main_q, main_d;
    payload_t          skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    payload_t          in_pay;
    logic              m_v;
    logic              s_v;
    logic              acc;
    logic              drn;

    // Saturating increment for the stall counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign in_pay = '{
        ctrl:   in_ctrl,
        rdata1: in_rdata1,
        rdata2: in_rdata2,
        imm:    in_imm,
        rs:     in_rs,
        rt:     in_rt,
        rd:     in_rd
    };

    assign m_v = state_q[1];
    assign s_v = state_q[0];

    // A flushed cycle never accepts, even if in_ready was high.
    assign acc = in_valid & in_ready_q & ~flush;
    assign drn = m_v & out_ready;

    // Next occupancy and payload movement; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_d  = in_pay;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (drn) begin
                        if (acc) begin
                            // Back-to-back transfer: stream straight through main.
                            main_d = in_pay;
                        end else begin
                            main_d  = '0;
                            state_d = ST_EMPTY;
                        end
                    end else if (acc) begin
                        // EX stalled while ID still had a payload in flight.
                        skid_d  = in_pay;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so the skid always moves up first.
                    if (drn) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // in_ready is registered and mirrors "skid empty" for the coming cycle.
    always_comb begin
        in_ready_d = (state_d != ST_FULL);
    end

    // Stall counter: counts valid-but-not-consumed cycles, independent of flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_v && !out_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // State, payload and counter registers; reset clears everything including data.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = m_v;
    assign out_ctrl   = main_q.ctrl;
    assign out_rdata1 = main_q.rdata1;
    assign out_rdata2 = main_q.rdata2;
    assign out_imm    = main_q.imm;
    assign out_rs     = main_q.rs;
    assign out_rt     = main_q.rt;
    assign out_rd     = main_q.rd;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table, hand-written corner sequences and
// a randomized run against a queue-based occupancy model.
module tb_id_ex_pipe_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 3;
    localparam int MAXC   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } pay_t;

    typedef struct {
        bit          rn;
        bit          fl;
        bit          iv;
        bit          ordy;
        logic [31:0] d;
        logic [7:0]  c;
        bit          e_ov;
        bit          e_ir;
        logic [31:0] e_d;
        logic [7:0]  e_c;
        int          e_st;
    } vec_t;

    logic             clock;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    pay_t             in_pay;
    pay_t             out_pay;
    logic [7:0]       out_ctrl;
    logic [31:0]      out_rdata1, out_rdata2, out_imm;
    logic [4:0]       out_rs, out_rt, out_rd;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t tbl[$];
    pay_t mq[$];
    int   mcnt;

    id_ex_pipe_reg #(
        .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_pay.ctrl),
        .in_rdata1  (in_pay.r1),
        .in_rdata2  (in_pay.r2),
        .in_imm     (in_pay.imm),
        .in_rs      (in_pay.rs),
        .in_rt      (in_pay.rt),
        .in_rd      (in_pay.rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_rdata1 (out_rdata1),
        .out_rdata2 (out_rdata2),
        .out_imm    (out_imm),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd),
        .stall_cnt  (stall_cnt)
    );

    assign out_pay = {out_ctrl, out_rdata1, out_rdata2, out_imm, out_rs, out_rt, out_rd};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    // Distinct, deterministic payload derived from a small seed value.
    function automatic pay_t mk(input logic [7:0] c, input logic [31:0] d);
        pay_t p;
        p.ctrl = c;
        p.r1   = d;
        p.r2   = ~d;
        p.imm  = d * 32'h9E3779B9;
        p.rs   = d[4:0];
        p.rt   = d[4:0] ^ 5'h15;
        p.rd   = ~d[4:0];
        return p;
    endfunction

    function automatic pay_t rnd_pay();
        pay_t p;
        p.ctrl = 8'($urandom);
        p.r1   = $urandom;
        p.r2   = $urandom;
        p.imm  = $urandom;
        p.rs   = 5'($urandom);
        p.rt   = 5'($urandom);
        p.rd   = 5'($urandom);
        return p;
    endfunction

    function automatic void addv(bit rn, bit fl, bit iv, bit ordy,
                                 logic [31:0] d, logic [7:0] c,
                                 bit e_ov, bit e_ir, logic [31:0] e_d,
                                 logic [7:0] e_c, int e_st);
        vec_t v;
        v.rn = rn; v.fl = fl; v.iv = iv; v.ordy = ordy; v.d = d; v.c = c;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_d = e_d; v.e_c = e_c; v.e_st = e_st;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries; EX sees the head.
    task automatic model_step();
        bit room;
        if (!reset_n) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (mq.size() > 0 && !out_ready && mcnt < MAXC) mcnt++;
            if (flush) begin
                mq.delete();
            end else begin
                room = (mq.size() < 2);
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && room) mq.push_back(in_pay);
            end
        end
    endtask

    task automatic drive(input bit rn, input bit fl, input bit iv, input bit ordy, input pay_t p);
        reset_n   = rn;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_pay    = p;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_state(input string nm, input bit ov, input bit ir, input pay_t p, input int st);
        chk({nm, "_ov"},  128'(out_valid), 128'(ov));
        chk({nm, "_ir"},  128'(in_ready),  128'(ir));
        chk({nm, "_pay"}, 128'(out_pay),   128'(p));
        chk({nm, "_st"},  128'(stall_cnt), 128'(st));
    endtask

    initial begin
        pay_t z;
        pay_t pa, pb, pc, pe;
        z = '0;
        drive(0, 0, 0, 0, z);

        // ---------------- vector table ----------------
        // reset held two cycles with a live offer, then released
        addv(0,0,1,1, 32'hDEADBEEF, 8'h5A, 0,1, 0, 0, 0);
        addv(0,0,1,1, 32'hCAFEF00D, 8'hA5, 0,1, 0, 0, 0);
        addv(1,0,0,1, 32'h0, 8'h0, 0,1, 0, 0, 0);
        // streaming 1..8 with EX always ready
        for (int i = 1; i <= 8; i++)
            addv(1,0,1,1, 32'(i), 8'(i), 1,1, 32'(i), 8'(i), 0);
        addv(1,0,0,1, 32'h0, 8'h0, 0,1, 0, 0, 0);
        // backpressure: 1 shown, 2 to skid, 3 held by ID, then release
        addv(0,0,0,1, 32'h0, 8'h0, 0,1, 0, 0, 0);
        addv(1,0,1,1, 32'd1, 8'd1, 1,1, 32'd1, 8'd1, 0);
        addv(1,0,1,0, 32'd2, 8'd2, 1,0, 32'd1, 8'd1, 1);
        addv(1,0,1,0, 32'd3, 8'd3, 1,0, 32'd1, 8'd1, 2);
        addv(1,0,1,0, 32'd3, 8'd3, 1,0, 32'd1, 8'd1, 3);
        addv(1,0,1,1, 32'd3, 8'd3, 1,1, 32'd2, 8'd2, 3);
        addv(1,0,1,1, 32'd3, 8'd3, 1,1, 32'd3, 8'd3, 3);
        addv(1,0,0,1, 32'h0, 8'h0, 0,1, 0, 0, 3);

        foreach (tbl[k]) begin
            drive(tbl[k].rn, tbl[k].fl, tbl[k].iv, tbl[k].ordy, mk(tbl[k].c, tbl[k].d));
            tick();
            chk_state($sformatf("tbl%0d", k), tbl[k].e_ov, tbl[k].e_ir,
                      tbl[k].e_ov ? mk(tbl[k].e_c, tbl[k].e_d) : z, tbl[k].e_st);
        end

        // ---------------- flush while FULL ----------------
        pa = mk(8'h11, 32'hA0); pb = mk(8'h22, 32'hB0);
        pc = mk(8'h33, 32'hC0); pe = mk(8'h44, 32'hE0);
        drive(0,0,0,0, z);  tick();
        drive(1,0,1,0, pa); tick(); chk_state("fl_a",   1, 1, pa, 0);
        drive(1,0,1,0, pb); tick(); chk_state("fl_b",   1, 0, pa, 1);
        drive(1,0,1,0, pc); tick(); chk_state("fl_c",   1, 0, pa, 2);
        drive(1,1,1,0, mk(8'hFF, 32'hD0)); tick();
        chk_state("fl_flush", 0, 1, z, 3);
        for (int i = 0; i < 3; i++) begin
            drive(1,0,0,1, z); tick();
            chk_state("fl_after", 0, 1, z, 3);
        end
        drive(1,0,1,1, pe); tick(); chk_state("fl_new", 1, 1, pe, 3);

        // ---------------- counter saturation ----------------
        drive(0,0,0,0, z);  tick();
        drive(1,0,1,0, pa); tick(); chk_state("sat_0", 1, 1, pa, 0);
        for (int k = 1; k <= 10; k++) begin
            drive(1,0,0,0, z); tick();
            chk_state($sformatf("sat_%0d", k), 1, 1, pa, (k < MAXC) ? k : MAXC);
        end

        // ---------------- reset while FULL ----------------
        drive(0,0,0,0, z);  tick();
        drive(1,0,1,0, pa); tick();
        drive(1,0,1,0, pb); tick(); chk_state("rs_full", 1, 0, pa, 1);
        drive(0,0,1,1, pc); tick(); chk_state("rs_rst",  0, 1, z, 0);
        drive(1,0,1,1, pe); tick(); chk_state("rs_new",  1, 1, pe, 0);
        drive(1,0,0,1, z);  tick(); chk_state("rs_idle", 0, 1, z, 0);

        // ---------------- randomized run vs model ----------------
        drive(0,0,0,0, z); tick();
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0,199) != 0, $urandom_range(0,15) == 0,
                  $urandom_range(0,3) != 0, $urandom_range(0,1) == 1, rnd_pay());
            tick();
            chk_state("rnd", mq.size() > 0, mq.size() < 2,
                      (mq.size() > 0) ? mq[0] : z, mcnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline register with a valid/ready handshake and a one-entry skid buffer. It carries the decoded control word, both register-read operands, the sign-extended immediate and the Rs/Rt/Rd indices from decode into execute. It adds three things to a plain flushable register: backpressure from EX, bubble marking through a valid bit, and a saturating stall counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, width of rdata1, rdata2 and imm
- REG_W, 5, width of each register index
- CTRL_W, 8, width of the packed control word (RegWrite, MemtoReg, ALUSrc, MemWrite, RegDst, MemRead, ALUOp[1:0])
- CNT_W, 16, width of the stall counter

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  reset, synchronous and active-low
- flush  in  1  discard all held and incoming content this cycle
- in_valid  in  1  ID presents a payload
- in_ready  out  1  stage can accept; registered
- in_ctrl / in_rdata1 / in_rdata2 / in_imm  in  CTRL_W / DATA_W / DATA_W / DATA_W  ID payload
- in_rs / in_rt / in_rd  in  REG_W each  ID register indices
- out_valid  out  1  EX payload valid
- out_ready  in  1  EX consumes the payload
- out_ctrl / out_rdata1 / out_rdata2 / out_imm / out_rs / out_rt / out_rd  out  widths as inputs  EX payload
- stall_cnt  out  CNT_W  cycles spent with out_valid=1 and out_ready=0

## Operation
- Storage consists of a main register (drives the out_* ports) and a skid register. Each has its own valid bit: m_v and s_v.
- Accept: acc = in_valid & in_ready & ~flush. Drain: drn = out_valid & out_ready.
- in_ready = ~s_v, registered. out_valid = m_v.
- Main update, in priority order:
  - flush: m_v=0.
  - drn & s_v: main<=skid, s_v=0.
  - drn & acc: main<=input.
  - drn: m_v=0.
  - ~m_v & acc: main<=input.
  - otherwise hold.
- Skid update:
  - flush: s_v=0.
  - m_v & ~out_ready & acc: skid<=input, s_v=1. This case arises only when s_v=0.
  - drained into main as above.
- Bubble rule: whenever out_valid=0, all out_* payload fields read zero. This applies after reset, after flush and after draining. The same rule applies to the skid contents when s_v=0.
- flush beats every other event in the same cycle. An input offered during flush is dropped even if in_ready=1.
- stall_cnt increments by 1 on each cycle with out_valid & ~out_ready. It saturates at 2^CNT_W-1, holds otherwise, is cleared only by reset, and is unaffected by flush.
- Effective states, as (m_v, s_v):
  - EMPTY (0,0): acc goes to ONE.
  - ONE (1,0): acc & ~out_ready goes to FULL; drn & ~acc goes to EMPTY; drn & acc stays in ONE.
  - FULL (1,1): drn goes to ONE.
  - flush from any state goes to EMPTY.
  - (0,1) is unreachable.

## Timing
- Reset (reset_n=0 at a rising edge): m_v=s_v=0, in_ready=1, out_valid=0, every out_* field=0, stall_cnt=0. Reset wins over flush and over every handshake. Reset asserted mid-transfer discards both entries.
- Latency: a payload accepted at edge N is visible on out_* after edge N, i.e. one cycle.
- Throughput: 1 payload per cycle while out_ready=1.
- in_ready falls the cycle after the skid fills. It rises the cycle after the skid drains. No payload is lost or duplicated under any out_ready pattern.
- Flush at edge N: out_valid=0 and in_ready=1 from edge N onward. A new accept can occur at edge N+1.
- Ordering: the skid payload always reaches EX before any later input.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 and random payload, then release. Required: out_valid=0, all out_* fields=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, in_valid=1, rdata1=1..8 on 8 consecutive cycles. Required: out_valid high for 8 cycles, out_rdata1=1..8 in order, each 1 cycle later, stall_cnt=0.
- Backpressure: stream 1,2,3 and drop out_ready after payload 1 appears. Required: out_rdata1 holds 1, payload 2 goes to the skid, in_ready=0 from the next cycle, and 3 is held by ID. Raise out_ready. Required: EX sees 2 then 3, and stall_cnt equals the number of low-ready cycles with valid output.
- Flush while FULL: reach FULL, then pulse flush with in_valid=1 and ctrl=8'hFF. Required: next cycle out_valid=0, out_ctrl=0, in_ready=1, no later appearance of any of the three payloads, and stall_cnt retained.
- Saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles. Required: stall_cnt reaches 7 and holds at 7.
- Reset mid-operation: reach FULL, then assert reset_n=0 together with out_ready=1. Required: both entries discarded, outputs return to their reset values, and a fresh accept works on the first cycle after release.
